apb_completer_regs: RTL

- APB completer (slave) that is the responder end of the APB requester used in this design; decodes a fixed address window and serves a small bank of 32-bit registers.
- Inserts a programmable number of wait states, then completes the transfer with pready. Flags bad accesses with pslverr.
- Register contents are exported to the surrounding logic. The top register is a read-only ID.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_addr_decode.sv | 26 ++
 rtl/apb_completer_regs.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, the default register window base and the
// completer FSM state encoding.
package apb_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;

  // Default window base, shared with the requester side of the design.
  localparam logic [APB_AW-1:0] APB_BASE_ADDR = 32'hA000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational decode of a latched byte address into a register index,
// a validity flag and a read-only (ID register) flag.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int unsigned       NUM_REGS  = 8,
  parameter logic [APB_AW-1:0] BASE_ADDR = APB_BASE_ADDR
) (
  input  logic [APB_AW-1:0] addr,
  output logic              valid,
  output logic [3:0]        idx,
  output logic              read_only
);

  // One bit wider than the bus so a window near the top of memory cannot wrap.
  localparam logic [APB_AW:0] LIMIT = {1'b0, BASE_ADDR} + (APB_AW+1)'(4 * NUM_REGS);

  always_comb begin
    idx       = 4'((addr - BASE_ADDR) >> 2);
    valid     = (addr[1:0] == 2'b00) &&
                (addr >= BASE_ADDR) &&
                ({1'b0, addr} < LIMIT);
    read_only = valid && (idx == 4'(NUM_REGS - 1));
  end

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer serving a bank of 32-bit registers with programmable wait
// states; the top register is a read-only ID, the rest are exported on regs_o.
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int unsigned       NUM_REGS    = 8,
  parameter logic [APB_AW-1:0] BASE_ADDR   = APB_BASE_ADDR,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [APB_DW-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic [APB_AW-1:0]        paddr,
  input  logic                     pwrite,
  input  logic [APB_DW-1:0]        pwdata,
  output logic [APB_DW-1:0]        prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_stb
);

  localparam int unsigned NW = NUM_REGS - 1;

  // Handshake: a transfer starts with a setup cycle (psel=1, penable=0) that
  // latches address/direction/data; it completes in the access cycle where
  // pready=1, and that same clock edge commits the write. pslverr and prdata
  // are meaningful only while pready=1. Dropping psel mid-access abandons it.

  apb_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [APB_AW-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [APB_DW-1:0]   wdata_q, wdata_d;
  logic [APB_DW-1:0]   regs_q [NW];
  logic [APB_DW-1:0]   regs_d [NW];
  logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;

  logic                dec_valid;
  logic [3:0]          dec_idx;
  logic                dec_ro;
  logic                err;
  logic                commit_wr;
  logic [APB_DW-1:0]   rd_data;

  apb_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr      (addr_q),
    .valid     (dec_valid),
    .idx       (dec_idx),
    .read_only (dec_ro)
  );

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wr_stb_q <= '0;
      for (int i = 0; i < NW; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      wr_stb_q <= wr_stb_d;
      for (int i = 0; i < NW; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d = ST_ACCESS;
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pready    = (state_q == ST_ACCESS) && psel && (cnt_q == 4'd0);
    err       = !dec_valid || (write_q && dec_ro);
    pslverr   = pready && err;
    commit_wr = pready && write_q && !err;

    rd_data = '0;
    if (dec_ro) begin
      rd_data = ID_VALUE;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (dec_idx == 4'(i)) rd_data = regs_q[i];
      end
    end
    prdata = (pready && !write_q && !err) ? rd_data : '0;
  end

  always_comb begin
    wr_stb_d = '0;
    for (int i = 0; i < NW; i++) begin
      regs_d[i] = regs_q[i];
      if (commit_wr && (dec_idx == 4'(i))) begin
        regs_d[i]   = wdata_q;
        wr_stb_d[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_regs_o
    assign regs_o[32*g +: 32] = regs_q[g];
  end
  assign regs_o[32*NW +: 32] = ID_VALUE;
  assign wr_stb              = wr_stb_q;

endmodule
